multi_counter: RTL and testbench
================================

MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each channel counter.
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 4, giving the number of independent counter channels.
REQ-003 The block SHALL have parameter COUNT_FROM, default 0, giving the lower bound and reset value.
REQ-004 The block SHALL have parameter COUNT_TO, default 2**(DATA_WIDTH-1), giving the upper bound.
REQ-005 The block SHALL have parameter STEP, default 1, giving the increment/decrement magnitude.
REQ-006 The block SHALL accept only 0 <= COUNT_FROM < COUNT_TO <= 2**DATA_WIDTH-1 and 1 <= STEP <= COUNT_TO-COUNT_FROM; elaboration SHALL fail otherwise.
REQ-007 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 clear  in  1  synchronous clear of all channels, active high.
REQ-010 load  in  NUM_CHANNELS  per-channel synchronous load strobe.
REQ-011 load_value  in  NUM_CHANNELS*DATA_WIDTH  per-channel load data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 count_enable  in  NUM_CHANNELS  per-channel count enable.
REQ-013 up_down  in  NUM_CHANNELS  per-channel direction (1 = up, 0 = down).
REQ-014 saturate  in  NUM_CHANNELS  per-channel boundary mode (0 = wrap, 1 = saturate).
REQ-015 count  out  NUM_CHANNELS*DATA_WIDTH  registered channel values, same packing as load_value.
REQ-016 at_limit  out  NUM_CHANNELS  combinational flag: count==COUNT_TO when up_down=1, count==COUNT_FROM when up_down=0.
REQ-017 boundary_pulse  out  NUM_CHANNELS  registered one-cycle flag marking a boundary event.

Function
REQ-018 Per-channel priority SHALL be: clear > load > count_enable > hold.
REQ-019 clear SHALL set every channel to COUNT_FROM and clear boundary_pulse on the next edge.
REQ-020 load[i] SHALL set channel i to load_value[i] verbatim (no range clamping) and clear boundary_pulse[i].
REQ-021 Up (enable, up_down=1), count < COUNT_TO: next = min(count+STEP, COUNT_TO), computed in DATA_WIDTH+1 bits without overflow.
REQ-022 Up, count >= COUNT_TO: next = COUNT_FROM (wrap) or COUNT_TO (saturate); boundary event.
REQ-023 Down, count > COUNT_FROM: next = max(count-STEP, COUNT_FROM), computed without underflow.
REQ-024 Down, count <= COUNT_FROM: next = COUNT_TO (wrap) or COUNT_FROM (saturate); boundary event.
REQ-025 A loaded out-of-range value (> COUNT_TO) SHALL be treated by REQ-021..024 unchanged (up: boundary on next enable; down: normal decrement).
REQ-026 boundary_pulse[i] SHALL be high for exactly the cycle in which count[i] shows the post-event value, then low unless another boundary event occurs (continuous in saturate mode while held enabled at the bound).
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-028 Changing up_down or saturate takes effect on the next enabled edge; no pipeline latency.
REQ-029 Count latency SHALL be one clock from enable sample to updated count.

Reset
REQ-030 reset high SHALL immediately, without clock, set all count to COUNT_FROM and boundary_pulse to 0, overriding any in-progress operation.
REQ-031 After reset deassertion the first rising edge SHALL be evaluated normally.

Verification
REQ-032 Defaults; reset, then enable ch0 up, wrap, 129 cycles -> count0 0..128 then 0; boundary_pulse0 high only in cycle count0=0 after 128.
REQ-033 Ch1 saturate, up, STEP=1, from 127, 3 enables -> 128,128,128; boundary_pulse1 high for the 2nd and 3rd cycles.
REQ-034 Ch2 down, wrap, from 0 -> 128 with pulse; STEP=3 build: load 130, up -> 0 wrap; load 2, down -> 0 (clamped, no pulse), then 128 with pulse.
REQ-035 Same edge: clear=1, load3=1 (value 50), enable3=1 -> count3=0; next edge load3 only -> 50; load with enable -> 50 (load wins).
REQ-036 Assert reset mid-count between edges at count=77 -> count=0, boundary_pulse=0 immediately; counting resumes from 0 after release.
REQ-037 Random per-channel stimulus 10k cycles against a reference model -> exact match of count, at_limit, boundary_pulse each cycle.

Source files
------------

// File: rtl/multi_counter.sv
// Bank of independent up/down counters with per-channel load, wrap/saturate
// boundary handling and a registered boundary-event pulse.
module multi_counter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned COUNT_FROM   = 0,
    parameter int unsigned COUNT_TO     = 2 ** (DATA_WIDTH - 1),
    parameter int unsigned STEP         = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [NUM_CHANNELS-1:0]            load,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] load_value,
    input  logic [NUM_CHANNELS-1:0]            count_enable,
    input  logic [NUM_CHANNELS-1:0]            up_down,
    input  logic [NUM_CHANNELS-1:0]            saturate,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] count,
    output logic [NUM_CHANNELS-1:0]            at_limit,
    output logic [NUM_CHANNELS-1:0]            boundary_pulse
);

    localparam longint unsigned MAX_VAL = (64'd1 << DATA_WIDTH) - 64'd1;

    generate
        if (DATA_WIDTH < 1 || DATA_WIDTH > 31 || NUM_CHANNELS < 1 ||
            COUNT_FROM >= COUNT_TO || longint'(COUNT_TO) > longint'(MAX_VAL) ||
            STEP < 1 || STEP > COUNT_TO - COUNT_FROM) begin : g_bad_params
            $error("multi_counter: illegal parameter combination");
        end
    endgenerate

    // Arithmetic is done one bit wider so count+STEP cannot overflow.
    localparam logic [DATA_WIDTH:0]   FROM_E = (DATA_WIDTH + 1)'(COUNT_FROM);
    localparam logic [DATA_WIDTH:0]   TO_E   = (DATA_WIDTH + 1)'(COUNT_TO);
    localparam logic [DATA_WIDTH:0]   STEP_E = (DATA_WIDTH + 1)'(STEP);
    localparam logic [DATA_WIDTH-1:0] FROM_N = DATA_WIDTH'(COUNT_FROM);
    localparam logic [DATA_WIDTH-1:0] TO_N   = DATA_WIDTH'(COUNT_TO);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] cnt_q;
            logic [DATA_WIDTH-1:0] cnt_d;
            logic                  pulse_q;
            logic                  pulse_d;
            logic [DATA_WIDTH:0]   cur;
            logic [DATA_WIDTH:0]   sum;
            logic [DATA_WIDTH:0]   step_nxt;
            logic                  step_ev;

            always_comb begin
                cur      = {1'b0, cnt_q};
                sum      = cur + STEP_E;
                step_nxt = cur;
                step_ev  = 1'b0;
                if (up_down[gi]) begin
                    if (cur < TO_E) begin
                        step_nxt = (sum > TO_E) ? TO_E : sum;
                    end else begin
                        step_nxt = saturate[gi] ? TO_E : FROM_E;
                        step_ev  = 1'b1;
                    end
                end else begin
                    // Compare the distance to the floor first so the subtraction never underflows.
                    if (cur > FROM_E) begin
                        step_nxt = ((cur - FROM_E) < STEP_E) ? FROM_E : (cur - STEP_E);
                    end else begin
                        step_nxt = saturate[gi] ? FROM_E : TO_E;
                        step_ev  = 1'b1;
                    end
                end
            end

            always_comb begin
                cnt_d   = cnt_q;
                pulse_d = 1'b0;
                if (clear) begin
                    cnt_d = FROM_N;
                end else if (load[gi]) begin
                    cnt_d = load_value[gi*DATA_WIDTH +: DATA_WIDTH];
                end else if (count_enable[gi]) begin
                    cnt_d   = step_nxt[DATA_WIDTH-1:0];
                    pulse_d = step_ev;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_q   <= FROM_N;
                    pulse_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    pulse_q <= pulse_d;
                end
            end

            assign count[gi*DATA_WIDTH +: DATA_WIDTH] = cnt_q;
            assign boundary_pulse[gi] = pulse_q;
            assign at_limit[gi] = up_down[gi] ? (cnt_q == TO_N) : (cnt_q == FROM_N);
        end
    endgenerate

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter: directed scenarios plus randomized
// traffic compared each cycle against an arithmetic reference model.
module tb_multi_counter;

    localparam int FROM = 0;
    localparam int TO   = 128;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  load = '0;
    logic [31:0] load_value = '0;
    logic [3:0]  en = '0;
    logic [3:0]  ud = '0;
    logic [3:0]  sat = '0;
    logic [31:0] count;
    logic [3:0]  at_limit;
    logic [3:0]  bp;

    logic        clr3 = 1'b0;
    logic        ld3 = 1'b0;
    logic [7:0]  lv3 = '0;
    logic        en3 = 1'b0;
    logic        ud3 = 1'b0;
    logic        sat3 = 1'b0;
    logic [7:0]  c3;
    logic        al3;
    logic        bp3;

    int m_cnt[4];
    bit m_pls[4];
    int m3_cnt;
    bit m3_pls;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    multi_counter dut (
        .clock(clock), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .count_enable(en), .up_down(ud),
        .saturate(sat), .count(count), .at_limit(at_limit),
        .boundary_pulse(bp)
    );

    multi_counter #(.NUM_CHANNELS(1), .STEP(3)) dut3 (
        .clock(clock), .reset(reset), .clear(clr3), .load(ld3),
        .load_value(lv3), .count_enable(en3), .up_down(ud3),
        .saturate(sat3), .count(c3), .at_limit(al3),
        .boundary_pulse(bp3)
    );

    function automatic int model_next(int c, bit up, bit s, int step, output bit ev);
        ev = 1'b0;
        if (up) begin
            if (c < TO) return (c + step > TO) ? TO : c + step;
            ev = 1'b1;
            return s ? TO : FROM;
        end
        if (c > FROM) return (c - step < FROM) ? FROM : c - step;
        ev = 1'b1;
        return s ? FROM : TO;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = FROM;
            m_pls[i] = 1'b0;
        end
        m3_cnt = FROM;
        m3_pls = 1'b0;
    endtask

    task automatic model_tick();
        bit ev;
        for (int i = 0; i < 4; i++) begin
            if (clear) begin
                m_cnt[i] = FROM; m_pls[i] = 1'b0;
            end else if (load[i]) begin
                m_cnt[i] = int'(load_value[i*8 +: 8]); m_pls[i] = 1'b0;
            end else if (en[i]) begin
                m_cnt[i] = model_next(m_cnt[i], ud[i], sat[i], 1, ev); m_pls[i] = ev;
            end else begin
                m_pls[i] = 1'b0;
            end
        end
        if (clr3) begin
            m3_cnt = FROM; m3_pls = 1'b0;
        end else if (ld3) begin
            m3_cnt = int'(lv3); m3_pls = 1'b0;
        end else if (en3) begin
            m3_cnt = model_next(m3_cnt, ud3, sat3, 3, ev); m3_pls = ev;
        end else begin
            m3_pls = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("count%0d", i), 32'(count[i*8 +: 8]), 32'(m_cnt[i]));
            check($sformatf("pulse%0d", i), 32'(bp[i]), 32'(m_pls[i]));
            check($sformatf("at_limit%0d", i), 32'(at_limit[i]),
                  32'(ud[i] ? (m_cnt[i] == TO) : (m_cnt[i] == FROM)));
        end
        check("s3_count", 32'(c3), 32'(m3_cnt));
        check("s3_pulse", 32'(bp3), 32'(m3_pls));
        check("s3_at_limit", 32'(al3), 32'(ud3 ? (m3_cnt == TO) : (m3_cnt == FROM)));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_tick();
        compare_all();
    endtask

    task automatic idle();
        clear = 1'b0; load = '0; en = '0; clr3 = 1'b0; ld3 = 1'b0; en3 = 1'b0;
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1;
        #2;
        check("reset_count", count, 32'd0);
        check("reset_pulse", 32'(bp), 32'd0);
        check("reset_count3", 32'(c3), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Ch0 up wrap through full range
        ud[0] = 1'b1; sat[0] = 1'b0; en[0] = 1'b1;
        for (int k = 0; k < 128; k++) tick();
        check("ch0_top", 32'(count[7:0]), 32'd128);
        check("ch0_top_pulse", 32'(bp[0]), 32'd0);
        tick();
        check("ch0_wrap", 32'(count[7:0]), 32'd0);
        check("ch0_wrap_pulse", 32'(bp[0]), 32'd1);
        en[0] = 1'b0;
        tick();
        check("ch0_pulse_drop", 32'(bp[0]), 32'd0);

        // Ch1 saturate up from 127
        load[1] = 1'b1; load_value[15:8] = 8'd127;
        tick();
        load[1] = 1'b0; ud[1] = 1'b1; sat[1] = 1'b1; en[1] = 1'b1;
        tick();
        check("ch1_sat1", 32'(count[15:8]), 32'd128);
        check("ch1_sat1_pulse", 32'(bp[1]), 32'd0);
        tick();
        check("ch1_sat2_pulse", 32'(bp[1]), 32'd1);
        tick();
        check("ch1_sat3", 32'(count[15:8]), 32'd128);
        check("ch1_sat3_pulse", 32'(bp[1]), 32'd1);
        en[1] = 1'b0;

        // Ch2 down wrap from 0
        ud[2] = 1'b0; sat[2] = 1'b0; en[2] = 1'b1;
        tick();
        check("ch2_down_wrap", 32'(count[23:16]), 32'd128);
        check("ch2_down_pulse", 32'(bp[2]), 32'd1);
        en[2] = 1'b0;

        // STEP=3 instance: out-of-range load then up, clamp on the way down
        ld3 = 1'b1; lv3 = 8'd130;
        tick();
        ld3 = 1'b0; ud3 = 1'b1; sat3 = 1'b0; en3 = 1'b1;
        tick();
        check("s3_oor_wrap", 32'(c3), 32'd0);
        check("s3_oor_pulse", 32'(bp3), 32'd1);
        en3 = 1'b0; ld3 = 1'b1; lv3 = 8'd2;
        tick();
        ld3 = 1'b0; ud3 = 1'b0; en3 = 1'b1;
        tick();
        check("s3_clamp", 32'(c3), 32'd0);
        check("s3_clamp_pulse", 32'(bp3), 32'd0);
        tick();
        check("s3_down_wrap", 32'(c3), 32'd128);
        check("s3_down_pulse", 32'(bp3), 32'd1);
        en3 = 1'b0;

        // Ch3 priority: clear > load > enable
        clear = 1'b1; load[3] = 1'b1; load_value[31:24] = 8'd50; en[3] = 1'b1; ud[3] = 1'b1;
        tick();
        check("ch3_clear_wins", 32'(count[31:24]), 32'd0);
        clear = 1'b0; en[3] = 1'b0;
        tick();
        check("ch3_load", 32'(count[31:24]), 32'd50);
        load[3] = 1'b0; en[3] = 1'b1;
        tick();
        check("ch3_count", 32'(count[31:24]), 32'd51);
        load[3] = 1'b1;
        tick();
        check("ch3_load_wins", 32'(count[31:24]), 32'd50);
        idle();

        // Async reset mid-count at 77
        clear = 1'b1;
        tick();
        clear = 1'b0; ud[0] = 1'b1; en[0] = 1'b1;
        for (int k = 0; k < 77; k++) tick();
        check("ch0_77", 32'(count[7:0]), 32'd77);
        #3;
        reset = 1'b1;
        #1;
        check("async_count", count, 32'd0);
        check("async_pulse", 32'(bp), 32'd0);
        model_reset();
        #2;
        reset = 1'b0;
        tick();
        check("resume", 32'(count[7:0]), 32'd1);

        // Randomized traffic
        for (int k = 0; k < 10000; k++) begin
            clear = ($urandom_range(0, 199) == 0);
            clr3  = ($urandom_range(0, 199) == 0);
            load_value = $urandom;
            lv3 = 8'($urandom);
            ld3 = ($urandom_range(0, 15) == 0);
            en3 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) ud3 = ~ud3;
            if ($urandom_range(0, 15) == 0) sat3 = ~sat3;
            for (int i = 0; i < 4; i++) begin
                load[i] = ($urandom_range(0, 15) == 0);
                en[i]   = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 31) == 0) ud[i] = ~ud[i];
                if ($urandom_range(0, 15) == 0) sat[i] = ~sat[i];
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
